bcd_conv_arbiter: RTL and testbench
===================================

# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one binary-to-BCD converter (37-bit binary in, 11 BCD digits out, start/ready/done_tick handshake) among NREQ requesters. Examples are the baud-rate readout and the character/parity-error counters on the seven-segment display path. It captures the winner's operand, issues a single start, waits for done_tick with a watchdog, and returns the latched digits to the winner with a one-cycle response pulse. It also rejects operands that do not fit in 11 decimal digits without using the converter.

## Interface
- NREQ, 3: number of requesters (2..8).
- TIMEOUT, 64: maximum cycles in WAIT before abort; must be ≥ 40.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level; held until that requester's rsp_valid bit.
- req_bin  in  37*NREQ  operands; requester i uses bits [37*i+36 : 37*i].
- gnt  out  NREQ  one-hot grant; high from grant through DELIVER.
- busy  out  1  high in any state except IDLE.
- rsp_valid  out  NREQ  one-cycle pulse to the served requester.
- rsp_bcd  out  44  {dig10..dig0}, 4 bits each; held until the next response.
- rsp_err  out  1  qualifies rsp_valid: range error or timeout; held with rsp_bcd.
- cv_start  out  1  converter start; registered, one cycle.
- cv_bin  out  37  operand to converter; registered, stable from ISSUE to DELIVER.
- cv_ready  in  1  converter idle.
- cv_done_tick  in  1  converter completion; cv_dig is valid in this cycle.
- cv_dig  in  44  converter digits {dig10..dig0}.

## Operation
- **States:** IDLE, ISSUE, WAIT, DELIVER.
- **Round-robin pointer** `last`, reset to NREQ-1, so requester 0 wins first.
  - The search order starts at last+1 and wraps modulo NREQ.
  - `last` updates to the served index in DELIVER, including error responses.
- **IDLE:**
  - Waits for any req bit high and cv_ready=1. If cv_ready=0, it waits; there is no grant.
  - Winner w: set gnt[w] and latch req_bin[w] into cv_bin.
  - Range check on the latched operand: if it is > 99_999_999_999, set rsp_err=1 and rsp_bcd=0, then go directly to DELIVER. No cv_start is issued.
  - Otherwise go to ISSUE.
- **ISSUE:** cv_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
- **WAIT:**
  - On cv_done_tick: capture cv_dig into rsp_bcd, set rsp_err=0, go to DELIVER.
  - Watchdog increments each cycle. When it reaches TIMEOUT-1 without done_tick: rsp_bcd=0, rsp_err=1, go to DELIVER.
- **DELIVER:** rsp_valid[w]=1 for one cycle, update `last`, clear gnt on exit, go to IDLE.
- **Requester handshake:**
  - The requester drops req on the edge where it samples rsp_valid high.
  - A req dropped before grant is a withdrawal; it is never served.
  - A req dropped after grant does not cancel: the conversion completes and rsp_valid still pulses.
- **Stability:** req_bin changes after grant have no effect, because the operand is latched.
- **Spurious input:** cv_done_tick outside WAIT is ignored.
- **Reset:** rst_n low at any point returns to IDLE. No rsp_valid is produced for the aborted transaction; the converter is reset by the same rst_n.

## Timing
- Reset values: gnt=0, busy=0, rsp_valid=0, rsp_bcd=0, rsp_err=0, cv_start=0, cv_bin=0, state=IDLE, last=NREQ-1, watchdog=0.
- Normal latency, with req seen in IDLE at cycle 0:
  - ISSUE and cv_start at cycle 1.
  - Converter runs 37 shift cycles (2..38).
  - cv_done_tick at cycle 39.
  - rsp_valid at cycle 40.
  - IDLE at cycle 41; the next grant is possible in cycle 41.
- Range-error latency: rsp_valid at cycle 1.
- Timeout latency: rsp_valid at cycle TIMEOUT+1 after grant.
- busy is high in cycles 1..40 of a normal transaction.
- Simultaneous requests are served strictly in rotation; no requester waits more than NREQ-1 transactions.

## Test plan
- **Single request:** req[0]=1, req_bin[36:0]=1234567 → cv_start at cycle 1, rsp_valid=3'b001 at cycle 40, rsp_bcd=44'h00000_1234567 (digit order dig10..dig0), rsp_err=0.
- **Contention:** req=3'b111 held, with operands 5, 99_999_999_999 and 0 → service order 0,1,2, then 0 again. Requester 1 gets rsp_bcd=44'h99999999999. Exactly one cv_start per transaction.
- **Range error:** req[2]=1, operand 100_000_000_000 → rsp_valid[2] one cycle after grant, rsp_err=1, rsp_bcd=0, cv_start never asserted.
- **Timeout:** converter model never raises cv_done_tick, TIMEOUT=64 → rsp_valid at cycle 65 after grant, rsp_err=1. The arbiter then returns to IDLE and serves the next request normally.
- **Reset mid-WAIT:** rst_n low at cycle 20 → all outputs return to reset values and no rsp_valid appears. After release with req still high, requester 0 is served first.
- **Withdrawal and stale operand:** req[1] pulses for 1 cycle while requester 0 is in WAIT → requester 1 is never granted. Changing req_bin[0] during WAIT does not change rsp_bcd.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one binary-to-BCD converter among NREQ requesters.
// Out-of-range operands are answered with an error response without using the converter.
module bcd_conv_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [37*NREQ-1:0]   req_bin,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [43:0]          rsp_bcd,
    output logic                 rsp_err,
    output logic                 cv_start,
    output logic [36:0]          cv_bin,
    input  logic                 cv_ready,
    input  logic                 cv_done_tick,
    input  logic [43:0]          cv_dig
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [36:0] MAX_DEC = 37'd99_999_999_999;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   cur;
    logic [IW-1:0]   win;
    logic [IW:0]     idx;
    logic            found;
    logic [36:0]     win_bin;
    logic            range_err;
    logic [WW-1:0]   wd;
    logic            wd_expire;
    logic            take;

    // Search starts one past the last served index and wraps around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = {1'b0, last} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ))
                idx = idx - (IW+1)'(NREQ);
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    assign win_bin   = req_bin[37*win +: 37];
    assign range_err = (win_bin > MAX_DEC);
    assign take      = found && cv_ready;
    // The abort edge is the one on which the watchdog would reach TIMEOUT-1.
    assign wd_expire = (wd == WW'(TIMEOUT-2));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = range_err ? DELIVER : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cv_done_tick || wd_expire) state_nxt = DELIVER;
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_bcd   <= '0;
            rsp_err   <= 1'b0;
            cv_start  <= 1'b0;
            cv_bin    <= '0;
            last      <= IW'(NREQ-1);
            cur       <= '0;
            wd        <= '0;
        end else begin
            cv_start  <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: if (take) begin
                    gnt    <= NREQ'(1) << win;
                    cur    <= win;
                    cv_bin <= win_bin;
                    if (range_err) begin
                        rsp_bcd   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NREQ'(1) << win;
                    end else begin
                        cv_start  <= 1'b1;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    if (cv_done_tick) begin
                        rsp_bcd   <= cv_dig;
                        rsp_err   <= 1'b0;
                        rsp_valid <= gnt;
                    end else if (wd_expire) begin
                        rsp_bcd   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= gnt;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DELIVER: begin
                    last <= cur;
                    gnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a behavioural 37-cycle converter model.
module tb_bcd_conv_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req;
    logic [110:0]  req_bin;
    logic [2:0]    gnt;
    logic          busy;
    logic [2:0]    rsp_valid;
    logic [43:0]   rsp_bcd;
    logic          rsp_err;
    logic          cv_start;
    logic [36:0]   cv_bin;
    logic          cv_ready;
    logic          cv_done_tick;
    logic [43:0]   cv_dig;

    bcd_conv_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_bin(req_bin),
        .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd),
        .rsp_err(rsp_err), .cv_start(cv_start), .cv_bin(cv_bin),
        .cv_ready(cv_ready), .cv_done_tick(cv_done_tick), .cv_dig(cv_dig)
    );

    always #5 clk = ~clk;

    // Converter stand-in: start at cycle 1, done_tick at cycle 39.
    logic        running, hang, spur;
    int          cnt;
    logic [36:0] opnd;

    function automatic logic [43:0] to_bcd(input logic [36:0] b);
        logic [63:0] v;
        logic [43:0] r;
        v = 64'(b);
        r = '0;
        for (int i = 0; i < 11; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= 0;
            opnd    <= '0;
        end else if (cv_start) begin
            running <= 1'b1;
            cnt     <= 0;
            opnd    <= cv_bin;
        end else if (running) begin
            if (cnt == 37) running <= 1'b0;
            cnt <= cnt + 1;
        end
    end

    assign cv_ready     = !running;
    assign cv_done_tick = (running && cnt == 37 && !hang) || spur;
    assign cv_dig       = to_bcd(opnd);

    typedef struct {
        int          idx;
        logic [43:0] bcd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    logic drop_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(3'b001 << e.idx));
                check("rsp_bcd", 64'(rsp_bcd), 64'(e.bcd));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic cycle();
        @(negedge clk);
        if (drop_en) req = req & ~rsp_valid;
    endtask

    task automatic run_txn(output int k_start, output int k_rsp, output int nstart);
        k_start = -1;
        k_rsp   = -1;
        nstart  = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (cv_start) begin
                nstart++;
                if (k_start < 0) k_start = k;
            end
            if (rsp_valid != 3'b000) begin
                k_rsp = k;
                if (drop_en) req = req & ~rsp_valid;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"},       64'(gnt), 64'd0);
        check({tag, "_busy"},      64'(busy), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_bcd"},   64'(rsp_bcd), 64'd0);
        check({tag, "_rsp_err"},   64'(rsp_err), 64'd0);
        check({tag, "_cv_start"},  64'(cv_start), 64'd0);
        check({tag, "_cv_bin"},    64'(cv_bin), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ks, kr, ns;
        req = '0; req_bin = '0; drop_en = 1'b1; hang = 1'b0; spur = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        cycle();

        // Contention: all three held, rotation 0,1,2,0.
        drop_en = 1'b0;
        req_bin = {37'd0, 37'd99_999_999_999, 37'd5};
        sb.push_back('{0, 44'h5, 1'b0});
        sb.push_back('{1, 44'h99999999999, 1'b0});
        sb.push_back('{2, 44'h0, 1'b0});
        sb.push_back('{0, 44'h5, 1'b0});
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            run_txn(ks, kr, ns);
            check("cont_nstart", 64'(ns), 64'd1);
            check("cont_lat", 64'(kr), (t == 0) ? 64'd40 : 64'd41);
        end
        req = 3'b000;
        drop_en = 1'b1;
        cycle();

        // Single request, nominal latency.
        req_bin[36:0] = 37'd1234567;
        sb.push_back('{0, 44'h00000_1234567, 1'b0});
        req = 3'b001;
        run_txn(ks, kr, ns);
        check("single_start_cyc", 64'(ks), 64'd1);
        check("single_rsp_cyc", 64'(kr), 64'd40);
        check("single_nstart", 64'(ns), 64'd1);
        check("single_cv_bin", 64'(cv_bin), 64'd1234567);
        cycle();
        check("single_idle_busy", 64'(busy), 64'd0);
        check("single_idle_gnt", 64'(gnt), 64'd0);

        // Range error: answered without the converter.
        req_bin[110:74] = 37'd100_000_000_000;
        sb.push_back('{2, 44'h0, 1'b1});
        req = 3'b100;
        run_txn(ks, kr, ns);
        check("range_rsp_cyc", 64'(kr), 64'd1);
        check("range_nstart", 64'(ns), 64'd0);
        check("range_cv_bin", 64'(cv_bin), 64'd100_000_000_000);
        cycle();
        check("range_idle_busy", 64'(busy), 64'd0);

        // Timeout: converter never completes, then a normal follow-up.
        hang = 1'b1;
        req_bin[73:37] = 37'd42;
        sb.push_back('{1, 44'h0, 1'b1});
        req = 3'b010;
        run_txn(ks, kr, ns);
        check("tmo_rsp_cyc", 64'(kr), 64'd65);
        check("tmo_nstart", 64'(ns), 64'd1);
        hang = 1'b0;
        req_bin[36:0] = 37'd987654321;
        sb.push_back('{0, 44'h00987654321, 1'b0});
        req = 3'b001;
        run_txn(ks, kr, ns);
        check("post_tmo_rsp_cyc", 64'(kr), 64'd41);
        cycle();

        // Spurious done_tick in IDLE is ignored.
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        cycle();
        check("spur_busy", 64'(busy), 64'd0);
        check("spur_gnt", 64'(gnt), 64'd0);

        // Reset during WAIT: aborted, then requester 0 first.
        req_bin[36:0]  = 37'd777;
        req_bin[73:37] = 37'd55;
        req = 3'b011;
        repeat (20) cycle();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        cycle();
        cycle();
        rst_n = 1'b1;
        sb.push_back('{0, 44'h777, 1'b0});
        sb.push_back('{1, 44'h55, 1'b0});
        run_txn(ks, kr, ns);
        check("rst_first_cyc", 64'(kr), 64'd40);
        run_txn(ks, kr, ns);
        check("rst_second_cyc", 64'(kr), 64'd41);
        cycle();

        // Withdrawn request and operand change during WAIT.
        req_bin[36:0] = 37'd31415;
        sb.push_back('{0, 44'h31415, 1'b0});
        req = 3'b001;
        kr = -1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 10) begin
                req[1] = 1'b1;
                req_bin[36:0] = 37'd999;
            end
            if (k == 11) req[1] = 1'b0;
            if (rsp_valid != 3'b000) begin
                kr = k;
                req = req & ~rsp_valid;
                break;
            end
        end
        check("wd_rsp_cyc", 64'(kr), 64'd40);
        repeat (3) cycle();
        check("wd_no_gnt", 64'(gnt), 64'd0);
        check("wd_busy", 64'(busy), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
